alu_issue_unit: RTL and testbench
=================================

# alu_issue_unit

Upstream issue/writeback controller for the `ALU`. Accepts one encoded register-register or register-immediate instruction per handshake, reads operands from an internal 8×32 register file, and drives the ALU's `instruction`/`num1`/`num2` inputs. It waits out the ALU's clocked latency, then writes `result` back to the destination register and latches `flags` into a status register. Together with the ALU it forms the execute core of the microprocessor.

## Interface
- `ALU_LAT`, default 1: clock edges between the ALU sampling its inputs and its `result`/`flags` being valid (≥1).
- `clk`  in  1  single clock; all state updates on rising edge.
- `rst`  in  1  asynchronous, active-high reset.
- `instr_in`  in  19  [18:14] op, [13] imm_sel, [12:10] rd, [9:7] rn, [6:0] imm7 when imm_sel=1, else [2:0] is rm.
- `instr_valid`  in  1  `instr_in` is valid.
- `instr_ready`  out  1  unit can accept; high only in IDLE.
- `alu_instruction`  out  5  op to ALU (registered).
- `alu_num1`  out  32  operand A = R[rn] (registered).
- `alu_num2`  out  32  operand B = R[rm], or zero-extended imm7 (registered).
- `alu_result`  in  32  ALU result.
- `alu_flags`  in  4  ALU flags.
- `flags_q`  out  4  latched status flags.
- `done`  out  1  one-cycle pulse after retirement.
- `illegal`  out  1  one-cycle pulse for op > 18.
- `dbg_addr`  in  3  debug read index.
- `dbg_data`  out  32  combinational R[dbg_addr].

## Operation
- Opcodes match the ALU encoding: 0=NOP, 1–18 valid (1 ANDS … 8 SUB, 9 MULS … 18 CMP), 19–31 illegal.
- FSM states: IDLE, ISSUE, EXEC, WB.
  - IDLE: `instr_ready`=1. On `instr_valid`: latch `instr_in`.
    - op 0: stay IDLE, pulse `done`.
    - op > 18: stay IDLE, pulse `illegal` (no `done`).
    - else: go to ISSUE.
  - ISSUE: register `alu_instruction`, `alu_num1`, `alu_num2`; load latency counter with `ALU_LAT`; go to EXEC.
  - EXEC: decrement the counter each edge; go to WB when it reaches 0. ALU outputs hold constant during EXEC and WB.
  - WB: at the ending edge, `flags_q` ← `alu_flags`. Unless op = 18 (CMP, flags only), also R[rd] ← `alu_result`. Pulse `done`; go to IDLE.
- Operands are read in ISSUE. rd = rn or rd = rm uses the pre-write value. No hazards are possible: only one instruction is in flight.
- All 8 registers are writable, R0 included.
- `alu_*` outputs keep their last value in IDLE. They are not cleared after retirement.

## Timing
- Reset (async assert, sync release) sets:
  - state IDLE, all R[i]=0, `flags_q`=0;
  - `alu_instruction`=0, `alu_num1`=0, `alu_num2`=0;
  - `done`=0, `illegal`=0, latched instr=0.
  - `instr_ready`=1 from the first cycle after release.
- Handshake edge E0. ALU inputs are visible after E1. WB write occurs at E(2+ALU_LAT). `done` is high for the cycle after that edge.
- With ALU_LAT=1: write at E3, `done` after E3, `instr_ready` high again after E3. Throughput is 1 instruction per 4 cycles.
- NOP/illegal: `done`/`illegal` high the cycle after E0; `instr_ready` stays high, so back-to-back acceptance is allowed.
- `instr_valid` while not ready: ignored; no buffering.
- `rst` mid-instruction: abort immediately. No register or flag write, no `done`.
- `done` and `illegal` are never high together. Each is exactly one cycle wide.

## Test plan
- After reset, issue ADDS (op 6) rd=1, rn=0, imm=15. Expect `alu_num1`=0 and `alu_num2`=15 after E1; `done` after E3; `dbg_addr`=1 reads 15.
- ANDS (op 1) rd=2, rn=1, imm=10 (R1=15) → R2=10. Then EORS (op 4) rd=3, rn=2, rm=1 → R3=5 (10^15). `instr_ready` is low for exactly 3 cycles per instruction.
- CMP (op 18) rn=1 (15), rm=2 (10), rd=1. Expect R1 unchanged at 15; `flags_q` equals the ALU's `flags` for 15-10 (Z=0, C=1); `done` pulses.
- Issue op 25, then NOP. Expect `illegal` pulse then `done` pulse on consecutive cycles; no register or flag change.
- ALU_LAT=3 build: MULS (op 9) rd=4, rn=3 (5), imm=4. Expect R4=20 written at E5; `alu_*` stable E1–E5.
- Assert `rst` one cycle after the handshake of ADDS rd=5, imm=99. Expect R5=0, `flags_q`=0, no `done`, `instr_ready`=1 after release.

Source files
------------

// File: rtl/alu_issue_unit.sv
`timescale 1ns/1ps
// alu_issue_unit: single-issue operand fetch and writeback controller in front of a clocked ALU.
// One instruction is in flight at a time; an 8x32 register file supplies operands and takes results.
module alu_issue_unit #(
   parameter int ALU_LAT = 1
) (
   input  logic        clk,
   input  logic        rst,
   input  logic [18:0] instr_in,
   input  logic        instr_valid,
   output logic        instr_ready,
   output logic [4:0]  alu_instruction,
   output logic [31:0] alu_num1,
   output logic [31:0] alu_num2,
   input  logic [31:0] alu_result,
   input  logic [3:0]  alu_flags,
   output logic [3:0]  flags_q,
   output logic        done,
   output logic        illegal,
   input  logic [2:0]  dbg_addr,
   output logic [31:0] dbg_data
);

   localparam logic [1:0] S_IDLE  = 2'd0;
   localparam logic [1:0] S_ISSUE = 2'd1;
   localparam logic [1:0] S_EXEC  = 2'd2;
   localparam logic [1:0] S_WB    = 2'd3;

   localparam logic [4:0] OP_NOP = 5'd0;
   localparam logic [4:0] OP_MAX = 5'd18;
   localparam logic [4:0] OP_CMP = 5'd18;

   localparam int CNT_W = $clog2(ALU_LAT + 1);

   logic [1:0]       state_q, state_d;
   logic [18:0]      instr_q, instr_d;
   logic [CNT_W-1:0] cnt_q, cnt_d;
   logic [4:0]       alu_op_q, alu_op_d;
   logic [31:0]      num1_q, num1_d;
   logic [31:0]      num2_q, num2_d;
   logic [3:0]       flags_d;
   logic             done_q, done_d;
   logic             illegal_q, illegal_d;
   logic             wb_en;
   logic [31:0]      rf_q [8];

   logic [4:0] op_in;
   logic [4:0] op_q;
   logic       imm_sel_q;
   logic [2:0] rd_q, rn_q, rm_q;
   logic [6:0] imm7_q;

   assign op_in     = instr_in[18:14];
   assign op_q      = instr_q[18:14];
   assign imm_sel_q = instr_q[13];
   assign rd_q      = instr_q[12:10];
   assign rn_q      = instr_q[9:7];
   assign rm_q      = instr_q[2:0];
   assign imm7_q    = instr_q[6:0];

   // NOTE: every signal gets a default at the top so no path through the case infers a latch.
   always_comb begin
      state_d   = state_q;
      instr_d   = instr_q;
      cnt_d     = cnt_q;
      alu_op_d  = alu_op_q;
      num1_d    = num1_q;
      num2_d    = num2_q;
      flags_d   = flags_q;
      done_d    = 1'b0;
      illegal_d = 1'b0;
      wb_en     = 1'b0;

      case (state_q)
         S_IDLE: begin
            if (instr_valid) begin
               instr_d = instr_in;
               if (op_in == OP_NOP) begin
                  done_d = 1'b1;
               end else if (op_in > OP_MAX) begin
                  illegal_d = 1'b1;
               end else begin
                  state_d = S_ISSUE;
               end
            end
         end
         S_ISSUE: begin
            alu_op_d = op_q;
            num1_d   = rf_q[rn_q];
            num2_d   = imm_sel_q ? {25'd0, imm7_q} : rf_q[rm_q];
            cnt_d    = CNT_W'(ALU_LAT);
            state_d  = S_EXEC;
         end
         S_EXEC: begin
            cnt_d = cnt_q - CNT_W'(1);
            if (cnt_q == CNT_W'(1)) begin
               state_d = S_WB;
            end
         end
         S_WB: begin
            // CMP updates only the status flags.
            flags_d = alu_flags;
            wb_en   = (op_q != OP_CMP);
            done_d  = 1'b1;
            state_d = S_IDLE;
         end
         default: state_d = S_IDLE;
      endcase
   end

   // NOTE: sequential state uses non-blocking assignments so every flop samples pre-edge values.
   always_ff @(posedge clk or posedge rst) begin
      if (rst) begin
         state_q   <= S_IDLE;
         instr_q   <= '0;
         cnt_q     <= '0;
         alu_op_q  <= '0;
         num1_q    <= '0;
         num2_q    <= '0;
         flags_q   <= '0;
         done_q    <= 1'b0;
         illegal_q <= 1'b0;
      end else begin
         state_q   <= state_d;
         instr_q   <= instr_d;
         cnt_q     <= cnt_d;
         alu_op_q  <= alu_op_d;
         num1_q    <= num1_d;
         num2_q    <= num2_d;
         flags_q   <= flags_d;
         done_q    <= done_d;
         illegal_q <= illegal_d;
      end
   end

   // NOTE: the register file is reset because software expects every register to read zero after reset.
   always_ff @(posedge clk or posedge rst) begin
      if (rst) begin
         for (int i = 0; i < 8; i++) begin
            rf_q[i] <= '0;
         end
      end else if (wb_en) begin
         rf_q[rd_q] <= alu_result;
      end
   end

   assign instr_ready     = (state_q == S_IDLE);
   assign alu_instruction = alu_op_q;
   assign alu_num1        = num1_q;
   assign alu_num2        = num2_q;
   assign done            = done_q;
   assign illegal         = illegal_q;
   assign dbg_data        = rf_q[dbg_addr];

endmodule

// File: tb/tb_alu_issue_unit.sv
`timescale 1ns/1ps
// tb_alu_issue_unit: table-driven bench with a clocked ALU model and a retirement scoreboard.
// Instance A runs with ALU_LAT=1, instance B with ALU_LAT=3.
module tb_alu_issue_unit;

   localparam int LAT_A = 1;
   localparam int LAT_B = 3;

   logic clk = 1'b0;
   logic rst;
   always #5 clk = ~clk;

   // Instance A
   logic [18:0] instr_in;
   logic        instr_valid, instr_ready;
   logic [4:0]  alu_instruction;
   logic [31:0] alu_num1, alu_num2, alu_result;
   logic [3:0]  alu_flags, flags_q;
   logic        done, illegal;
   logic [2:0]  dbg_addr;
   logic [31:0] dbg_data;

   // Instance B
   logic [18:0] instr_in_b;
   logic        instr_valid_b, instr_ready_b;
   logic [4:0]  alu_instruction_b;
   logic [31:0] alu_num1_b, alu_num2_b, alu_result_b;
   logic [3:0]  alu_flags_b, flags_q_b;
   logic        done_b, illegal_b;
   logic [2:0]  dbg_addr_b;
   logic [31:0] dbg_data_b;

   alu_issue_unit #(.ALU_LAT(LAT_A)) u_dut_a (
      .clk(clk), .rst(rst),
      .instr_in(instr_in), .instr_valid(instr_valid), .instr_ready(instr_ready),
      .alu_instruction(alu_instruction), .alu_num1(alu_num1), .alu_num2(alu_num2),
      .alu_result(alu_result), .alu_flags(alu_flags), .flags_q(flags_q),
      .done(done), .illegal(illegal), .dbg_addr(dbg_addr), .dbg_data(dbg_data)
   );

   alu_issue_unit #(.ALU_LAT(LAT_B)) u_dut_b (
      .clk(clk), .rst(rst),
      .instr_in(instr_in_b), .instr_valid(instr_valid_b), .instr_ready(instr_ready_b),
      .alu_instruction(alu_instruction_b), .alu_num1(alu_num1_b), .alu_num2(alu_num2_b),
      .alu_result(alu_result_b), .alu_flags(alu_flags_b), .flags_q(flags_q_b),
      .done(done_b), .illegal(illegal_b), .dbg_addr(dbg_addr_b), .dbg_data(dbg_data_b)
   );

   // ALU behaviour; flags packed {N,Z,C,V}, C = carry for add, no-borrow for subtract.
   function automatic logic [35:0] alu_ref(input logic [4:0] op, input logic [31:0] a, input logic [31:0] b);
      logic [32:0] w;
      logic [31:0] r;
      logic        c, v;
      c = 1'b0;
      v = 1'b0;
      case (op)
         5'd1: r = a & b;
         5'd4: r = a ^ b;
         5'd6: begin
            w = {1'b0, a} + {1'b0, b};
            r = w[31:0];
            c = w[32];
            v = (a[31] == b[31]) && (r[31] != a[31]);
         end
         5'd8, 5'd18: begin
            r = a - b;
            c = (a >= b);
            v = (a[31] != b[31]) && (r[31] != a[31]);
         end
         5'd9: r = a * b;
         default: r = a | b;
      endcase
      return {r[31], (r == 32'd0), c, v, r};
   endfunction

   logic [35:0] pipe_a [LAT_A];
   logic [35:0] pipe_b [LAT_B];

   always @(posedge clk) begin
      pipe_a[0] <= alu_ref(alu_instruction, alu_num1, alu_num2);
      for (int k = 1; k < LAT_A; k++) pipe_a[k] <= pipe_a[k-1];
      pipe_b[0] <= alu_ref(alu_instruction_b, alu_num1_b, alu_num2_b);
      for (int k = 1; k < LAT_B; k++) pipe_b[k] <= pipe_b[k-1];
   end

   assign {alu_flags, alu_result}     = pipe_a[LAT_A-1];
   assign {alu_flags_b, alu_result_b} = pipe_b[LAT_B-1];

   int n_checks = 0;
   int n_fail   = 0;

   task automatic check(input string name, input logic [31:0] act, input logic [31:0] exp);
      n_checks++;
      if (act !== exp) begin
         n_fail++;
         $display("FAIL %s: got 0x%0h, expected 0x%0h", name, act, exp);
      end
   endtask

   typedef struct {
      logic [4:0]  op;
      logic        imm_sel;
      logic [2:0]  rd;
      logic [2:0]  rn;
      logic [6:0]  src;      // imm7, or rm in [2:0]
      logic [31:0] exp_val;  // R[rd] after retirement
      logic [3:0]  exp_flg;
   } vec_t;

   typedef struct {
      logic        is_ill;
      logic        chk_reg;
      logic [31:0] val;
      logic [3:0]  flg;
   } sb_t;

   sb_t         sb_q[$];
   logic [31:0] model_r [8];
   logic [3:0]  model_flg;

   // Retirement monitor for instance A, sampled 1 ns after the rising edge.
   always @(posedge clk) begin
      sb_t e;
      #1;
      if (!rst && (done || illegal)) begin
         check("done_illegal_exclusive", 32'(done & illegal), 32'd0);
         if (sb_q.size() == 0) begin
            n_checks++;
            n_fail++;
            $display("FAIL unexpected_retire: done=%0b illegal=%0b with empty scoreboard", done, illegal);
         end else begin
            e = sb_q.pop_front();
            check("retire_kind_illegal", 32'(illegal), 32'(e.is_ill));
            check("retire_flags_q", 32'(flags_q), 32'(e.flg));
            if (e.chk_reg) check("retire_wb_value", dbg_data, e.val);
         end
      end
   end

   task automatic run_vec(input vec_t v);
      logic [31:0] a, b;
      int          low;
      bit          seen;
      a = model_r[v.rn];
      b = v.imm_sel ? {25'd0, v.src} : model_r[v.src[2:0]];
      @(negedge clk);
      dbg_addr    = v.rd;
      instr_in    = {v.op, v.imm_sel, v.rd, v.rn, v.src};
      instr_valid = 1'b1;
      sb_q.push_back('{is_ill: 1'b0, chk_reg: 1'b1, val: v.exp_val, flg: v.exp_flg});
      model_r[v.rd] = v.exp_val;
      model_flg     = v.exp_flg;
      @(negedge clk);
      instr_valid = 1'b0;
      low  = instr_ready ? 0 : 1;
      seen = 1'b0;
      for (int i = 1; i <= 20; i++) begin
         @(negedge clk);
         if (i == 1) begin
            check("issue_alu_instruction", 32'(alu_instruction), 32'(v.op));
            check("issue_alu_num1", alu_num1, a);
            check("issue_alu_num2", alu_num2, b);
         end
         if (done) begin
            seen = 1'b1;
            break;
         end
         if (!instr_ready) low++;
      end
      check("retired_within_budget", 32'(seen), 32'd1);
      check("ready_low_cycles", 32'(low), 32'd3);
   endtask

   // Issue on instance B and watch every cycle up to the writeback edge E(2+LAT_B).
   task automatic run_b(input logic [4:0] op, input logic imm_sel, input logic [2:0] rd,
                        input logic [2:0] rn, input logic [6:0] src,
                        input logic [31:0] exp_a, input logic [31:0] exp_b,
                        input logic [31:0] old_val, input logic [31:0] exp_val);
      @(negedge clk);
      dbg_addr_b    = rd;
      instr_in_b    = {op, imm_sel, rd, rn, src};
      instr_valid_b = 1'b1;
      @(negedge clk);
      instr_valid_b = 1'b0;
      for (int i = 1; i <= LAT_B + 2; i++) begin
         @(negedge clk);
         check("b_alu_instruction_stable", 32'(alu_instruction_b), 32'(op));
         check("b_alu_num1_stable", alu_num1_b, exp_a);
         check("b_alu_num2_stable", alu_num2_b, exp_b);
         if (i < LAT_B + 2) begin
            check("b_no_early_done", 32'(done_b), 32'd0);
            check("b_no_early_write", dbg_data_b, old_val);
         end else begin
            check("b_done_at_writeback", 32'(done_b), 32'd1);
            check("b_writeback_value", dbg_data_b, exp_val);
            check("b_flags_q", 32'(flags_q_b), 32'd0);
         end
      end
   endtask

   vec_t vecs [10];

   initial begin
      vecs[0] = '{5'd6,  1'b1, 3'd1, 3'd0, 7'd15,  32'd15,        4'b0000}; // ADDS R1=R0+15
      vecs[1] = '{5'd1,  1'b1, 3'd2, 3'd1, 7'd10,  32'd10,        4'b0000}; // ANDS R2=R1&10
      vecs[2] = '{5'd4,  1'b0, 3'd3, 3'd2, 7'd1,   32'd5,         4'b0000}; // EORS R3=R2^R1
      vecs[3] = '{5'd18, 1'b0, 3'd1, 3'd1, 7'd2,   32'd15,        4'b0010}; // CMP 15,10: R1 kept
      vecs[4] = '{5'd6,  1'b1, 3'd0, 3'd1, 7'd127, 32'd142,       4'b0000}; // max imm7, write R0
      vecs[5] = '{5'd8,  1'b0, 3'd7, 3'd2, 7'd1,   32'hFFFF_FFFB, 4'b1000}; // SUB 10-15
      vecs[6] = '{5'd6,  1'b1, 3'd3, 3'd3, 7'd1,   32'd6,         4'b0000}; // rd==rn
      vecs[7] = '{5'd8,  1'b0, 3'd2, 3'd3, 7'd3,   32'd0,         4'b0110}; // SUB 6-6 = 0
      vecs[8] = '{5'd6,  1'b0, 3'd6, 3'd7, 7'd7,   32'hFFFF_FFF6, 4'b1010}; // carry out
      vecs[9] = '{5'd18, 1'b0, 3'd4, 3'd0, 7'd0,   32'd0,         4'b0110}; // CMP 142,142

      for (int i = 0; i < 8; i++) model_r[i] = '0;
      model_flg     = '0;
      rst           = 1'b1;
      instr_in      = '0;
      instr_valid   = 1'b0;
      dbg_addr      = '0;
      instr_in_b    = '0;
      instr_valid_b = 1'b0;
      dbg_addr_b    = '0;
      repeat (3) @(negedge clk);
      rst = 1'b0;
      @(negedge clk);

      check("reset_instr_ready", 32'(instr_ready), 32'd1);
      check("reset_flags_q", 32'(flags_q), 32'd0);
      check("reset_done", 32'(done), 32'd0);
      check("reset_illegal", 32'(illegal), 32'd0);
      check("reset_alu_instruction", 32'(alu_instruction), 32'd0);
      check("reset_alu_num1", alu_num1, 32'd0);
      check("reset_alu_num2", alu_num2, 32'd0);
      check("reset_b_instr_ready", 32'(instr_ready_b), 32'd1);

      for (int i = 0; i < 10; i++) run_vec(vecs[i]);

      // Illegal op (would target R1) immediately followed by a NOP.
      @(negedge clk);
      instr_in    = {5'd25, 1'b1, 3'd1, 3'd0, 7'd127};
      instr_valid = 1'b1;
      sb_q.push_back('{is_ill: 1'b1, chk_reg: 1'b0, val: 32'd0, flg: model_flg});
      @(negedge clk);
      check("illegal_pulse", 32'(illegal), 32'd1);
      check("illegal_no_done", 32'(done), 32'd0);
      check("illegal_ready_stays_high", 32'(instr_ready), 32'd1);
      instr_in = {5'd0, 1'b0, 3'd2, 3'd0, 7'd0};
      sb_q.push_back('{is_ill: 1'b0, chk_reg: 1'b0, val: 32'd0, flg: model_flg});
      @(negedge clk);
      instr_valid = 1'b0;
      check("nop_done_pulse", 32'(done), 32'd1);
      check("nop_no_illegal", 32'(illegal), 32'd0);
      @(negedge clk);
      check("done_one_cycle", 32'(done), 32'd0);
      check("illegal_one_cycle", 32'(illegal), 32'd0);

      for (int i = 0; i < 8; i++) begin
         dbg_addr = 3'(i);
         #1;
         check($sformatf("regfile_r%0d", i), dbg_data, model_r[i]);
      end
      check("final_flags_q", 32'(flags_q), 32'(model_flg));

      // ALU_LAT=3 instance: R3 = 5, then MULS R4 = R3 * 4 written at E5.
      run_b(5'd6, 1'b1, 3'd3, 3'd0, 7'd5, 32'd0, 32'd5, 32'd0, 32'd5);
      run_b(5'd9, 1'b1, 3'd4, 3'd3, 7'd4, 32'd5, 32'd4, 32'd0, 32'd20);

      // Reset while an ADDS R5 = R0 + 99 is in flight.
      @(negedge clk);
      dbg_addr    = 3'd5;
      instr_in    = {5'd6, 1'b1, 3'd5, 3'd0, 7'd99};
      instr_valid = 1'b1;
      @(negedge clk);
      instr_valid = 1'b0;
      @(negedge clk);
      rst = 1'b1;
      #1;
      check("abort_async_ready", 32'(instr_ready), 32'd1);
      repeat (2) @(negedge clk);
      rst = 1'b0;
      for (int i = 0; i < 5; i++) begin
         @(negedge clk);
         check("abort_no_done", 32'(done), 32'd0);
      end
      check("abort_r5", dbg_data, 32'd0);
      check("abort_flags_q", 32'(flags_q), 32'd0);
      check("abort_instr_ready", 32'(instr_ready), 32'd1);
      check("abort_alu_num1", alu_num1, 32'd0);
      for (int i = 0; i < 8; i++) begin
         dbg_addr = 3'(i);
         #1;
         check($sformatf("abort_regfile_r%0d", i), dbg_data, 32'd0);
      end
      check("scoreboard_drained", 32'(sb_q.size()), 32'd0);

      $display("End of test - %0d assertions evaluated, %0d failures", n_checks, n_fail);
      $finish;
   end

   initial begin
      #200000;
      $display("FAIL global_timeout: simulation did not finish within 200000 ns");
      $fatal(1, "timeout");
   end

endmodule
